jtdd2_snd_romarb: RTL and testbench

Sound-board ROM arbiter for Double Dragon II. It shares one SDRAM read port between the Z80 program ROM (32 kB) and the MSM6295 ADPCM sample ROM (256 kB). It sits between the sound subsystem's two ROM interfaces and the framework SDRAM slot. Each requester has a one-word holding register with an address tag, so repeated reads of the same byte complete without a new SDRAM access.

---
 rtl/jtdd2_snd_romarb.sv | 107 ++++++++++
 tb/tb_jtdd2_snd_romarb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd2_snd_romarb.sv
// Sound ROM arbiter: Z80 program ROM and ADPCM ROM share one SDRAM read slot.
// Optional macro JTDD2_ROMARB_PCMPRIO_EN gives ADPCM fixed priority on simultaneous misses.
module jtdd2_snd_romarb #(
  parameter int               CPU_AW     = 15,
  parameter int               PCM_AW     = 18,
  parameter int               SD_AW      = 19,
  parameter logic [SD_AW-1:0] PCM_OFFSET = 19'h08000
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic              cpu_cs,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic [PCM_AW-1:0] pcm_addr,
  input  logic              pcm_cs,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic [SD_AW-1:0]  sd_addr,
  output logic              sd_cs,
  input  logic [7:0]        sd_data,
  input  logic              sd_ok
);
  localparam int PW = (CPU_AW > PCM_AW) ? CPU_AW : PCM_AW;

  typedef enum logic [1:0] {IDLE, GUARD, WAIT} st_t;
  st_t st;

  logic [CPU_AW-1:0] tag_cpu;
  logic [PCM_AW-1:0] tag_pcm;
  logic [7:0]        dat_cpu, dat_pcm;
  logic              vld_cpu, vld_pcm;
  logic [PW-1:0]     pend_addr;
  logic              gnt_pcm;
  logic              hit_cpu, hit_pcm, miss_cpu, miss_pcm, pick_pcm;

  assign hit_cpu  = vld_cpu & (cpu_addr == tag_cpu);
  assign hit_pcm  = vld_pcm & (pcm_addr == tag_pcm);
  assign miss_cpu = cpu_cs & ~hit_cpu;
  assign miss_pcm = pcm_cs & ~hit_pcm;
  assign cpu_ok   = cpu_cs & hit_cpu;
  assign pcm_ok   = pcm_cs & hit_pcm;
  assign cpu_data = dat_cpu;
  assign pcm_data = dat_pcm;

`ifdef JTDD2_ROMARB_PCMPRIO_EN
  assign pick_pcm = miss_pcm;
`else
  // rr_pcm: who wins the next simultaneous miss; only contended grants move it
  logic rr_pcm;
  assign pick_pcm = miss_pcm & (~miss_cpu | rr_pcm);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      rr_pcm <= 1'b0;
    else if (st == IDLE && miss_cpu && miss_pcm)
      rr_pcm <= ~pick_pcm;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= IDLE;
      sd_cs     <= 1'b0;
      sd_addr   <= '0;
      pend_addr <= '0;
      gnt_pcm   <= 1'b0;
      tag_cpu   <= '0;
      tag_pcm   <= '0;
      dat_cpu   <= '0;
      dat_pcm   <= '0;
      vld_cpu   <= 1'b0;
      vld_pcm   <= 1'b0;
    end else begin
      case (st)
        IDLE:
          if (miss_cpu || miss_pcm) begin
            gnt_pcm <= pick_pcm;
            sd_cs   <= 1'b1;
            st      <= GUARD;
            if (pick_pcm) begin
              sd_addr   <= PCM_OFFSET + SD_AW'(pcm_addr);
              pend_addr <= PW'(pcm_addr);
            end else begin
              sd_addr   <= SD_AW'(cpu_addr);
              pend_addr <= PW'(cpu_addr);
            end
          end
        // sd_ok may still belong to the previous address here
        GUARD: st <= WAIT;
        WAIT:
          if (sd_ok) begin
            sd_cs <= 1'b0;
            st    <= IDLE;
            if (gnt_pcm) begin
              dat_pcm <= sd_data;
              tag_pcm <= pend_addr[PCM_AW-1:0];
              vld_pcm <= 1'b1;
            end else begin
              dat_cpu <= sd_data;
              tag_cpu <= pend_addr[CPU_AW-1:0];
              vld_cpu <= 1'b1;
            end
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtdd2_snd_romarb.sv
// Scoreboard bench for jtdd2_snd_romarb: directed boundary cases then randomized traffic.
module tb_jtdd2_snd_romarb;
  logic        clk = 0, rst_n = 0;
  logic [14:0] cpu_addr = 0;
  logic        cpu_cs = 0;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic [17:0] pcm_addr = 0;
  logic        pcm_cs = 0;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [18:0] sd_addr;
  logic        sd_cs;
  logic [7:0]  sd_data = 0;
  logic        sd_ok = 0;

  always #10 clk = ~clk;

  jtdd2_snd_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .sd_addr(sd_addr), .sd_cs(sd_cs), .sd_data(sd_data), .sd_ok(sd_ok)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0]  cpu_q[$], pcm_q[$];
  logic [18:0] sd_log[$];
  int lat = 2, cs_cnt = 0, sdok_cyc = -1, cpu_ok_cyc = -1;
  bit stuck = 0;
  // reference state: what each holding register should contain
  logic [14:0] m_tag_cpu = 0;
  logic [17:0] m_tag_pcm = 0;
  bit m_vld_cpu = 0, m_vld_pcm = 0, m_next_pcm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fmem(logic [18:0] a);
    if (a == 19'h00123) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
  endfunction
  function automatic logic [18:0] map_cpu(logic [14:0] a);
    return {4'd0, a};
  endfunction
  function automatic logic [18:0] map_pcm(logic [17:0] a);
    return 19'h08000 + {1'b0, a};
  endfunction
  function automatic logic [18:0] log_back(int back);
    if (sd_log.size() < back) return 'x;
    return sd_log[sd_log.size() - back];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SDRAM model: answers lat cycles after sd_cs rises; in stuck mode sd_ok never drops
  initial forever begin
    @(posedge clk); #1;
    cs_cnt  = sd_cs ? cs_cnt + 1 : 0;
    sd_ok   = stuck || (sd_cs && cs_cnt == lat + 1);
    sd_data = (sd_cs && cs_cnt >= 2) ? fmem(sd_addr) : 8'hEE;
    if (sd_ok && sd_cs && cs_cnt >= 2) sdok_cyc = cyc;
  end

  // monitor: pops expectations whenever a requester reports ok
  logic        prev_cs = 0;
  logic [18:0] prev_addr = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (sd_cs && !prev_cs) sd_log.push_back(sd_addr);
      if (sd_cs && prev_cs && sd_addr !== prev_addr) chk("sd_addr_stable", sd_addr, prev_addr);
      if (!cpu_cs) chk("cpu_ok_without_cs", cpu_ok, 0);
      if (!pcm_cs) chk("pcm_ok_without_cs", pcm_ok, 0);
      if (cpu_ok && cpu_q.size() > 0) begin
        chk("cpu_data", cpu_data, cpu_q.pop_front());
        cpu_ok_cyc = cyc;
      end
      if (pcm_ok && pcm_q.size() > 0) chk("pcm_data", pcm_data, pcm_q.pop_front());
    end
    prev_cs   = sd_cs;
    prev_addr = sd_addr;
  end

  // issue one request per selected requester and wait for the scoreboard to drain
  task automatic req(input bit do_cpu, input bit do_pcm, input logic [14:0] ca, input logic [17:0] pa);
    bit hc, hp;
    int t, n0;
    hc = m_vld_cpu && m_tag_cpu == ca;
    hp = m_vld_pcm && m_tag_pcm == pa;
    n0 = sd_log.size();
    if (do_cpu) begin cpu_q.push_back(fmem(map_cpu(ca))); cpu_addr = ca; cpu_cs = 1; end
    if (do_pcm) begin pcm_q.push_back(fmem(map_pcm(pa))); pcm_addr = pa; pcm_cs = 1; end
    t = 0;
    while ((cpu_q.size() > 0 || pcm_q.size() > 0) && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("req_timeout", t, 0);
      cpu_q.delete(); pcm_q.delete();
      return;
    end
    if (do_cpu ^ do_pcm) begin
      if ((do_cpu && hc) || (do_pcm && hp)) begin
        chk("hit_latency", t, 1);
        chk("hit_no_sdram", sd_log.size(), n0);
      end else begin
        n_cmp++;
        if (t < 3) begin n_err++; $display("FAIL miss_latency: got %0d cycles, need >= 3", t); end
        chk("miss_one_fetch", sd_log.size(), n0 + 1);
      end
    end
    if (do_cpu) begin m_vld_cpu = 1; m_tag_cpu = ca; end
    if (do_pcm) begin m_vld_pcm = 1; m_tag_pcm = pa; end
  endtask

  initial begin
    logic [14:0] ca;
    logic [17:0] pa;
    bit pcm_first;
    int mode;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ok", cpu_ok, 0);
    chk("rst_pcm_ok", pcm_ok, 0);
    chk("rst_sd_cs", sd_cs, 0);
    chk("rst_sd_addr", sd_addr, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_pcm_data", pcm_data, 0);
    #1 rst_n = 1;
    @(negedge clk); #1;

    // first fetch with a 4-cycle SDRAM
    lat = 4;
    req(1, 0, 15'h0123, 0);
    chk("t1_sd_addr", log_back(1), 19'h00123);
    chk("t1_ok_cycle", cpu_ok_cyc, sdok_cyc + 1);
    chk("t1_pcm_ok", pcm_ok, 0);

    // toggling cs at the cached address never reaches SDRAM
    repeat (3) begin
      cpu_cs = 0;
      @(negedge clk); #1;
      chk("t2_ok_follows_cs", cpu_ok, 0);
      req(1, 0, 15'h0123, 0);
    end
    cpu_cs = 0;

    // top of ADPCM region, then address change while holding cs
    lat = 2;
    req(0, 1, 0, 18'h3FFFF);
    chk("t3_sd_addr_top", log_back(1), 19'h47FFF);
    pcm_addr = 18'h00000;
    #1 chk("t3_ok_drop_comb", pcm_ok, 0);
    req(0, 1, 0, 18'h00000);
    chk("t3_sd_addr_base", log_back(1), 19'h08000);
    pcm_cs = 0;

    // simultaneous misses: alternate winner, or PCM always under fixed priority
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      req(1, 1, 15'h0200 + 15'(r), 18'h01000 + 18'(r));
`ifdef JTDD2_ROMARB_PCMPRIO_EN
      pcm_first = 1;
`else
      pcm_first = m_next_pcm;
      m_next_pcm = !m_next_pcm;
`endif
      chk("t4_first_grant", log_back(2), pcm_first ? map_pcm(18'h01000 + 18'(r)) : map_cpu(15'h0200 + 15'(r)));
      chk("t4_second_grant", log_back(1), pcm_first ? map_cpu(15'h0200 + 15'(r)) : map_pcm(18'h01000 + 18'(r)));
      cpu_cs = 0; pcm_cs = 0;
    end

    // sd_ok stuck high: the guard cycle must still hide it
    @(negedge clk); #1;
    stuck = 1;
    req(1, 0, 15'h7ABC, 0);
    req(0, 1, 0, 18'h20ABC);
    stuck = 0;
    cpu_cs = 0;
    repeat (2) @(negedge clk);
    #1;

    // reset in the middle of a fetch
    lat = 6;
    cpu_addr = 15'h0444; cpu_cs = 1;
    repeat (4) @(negedge clk);
    chk("t6_pcm_ok_before", pcm_ok, 1);
    chk("t6_sd_cs_before", sd_cs, 1);
    #3 rst_n = 0;
    #1;
    chk("t6_sd_cs_async", sd_cs, 0);
    chk("t6_cpu_ok_async", cpu_ok, 0);
    chk("t6_pcm_ok_async", pcm_ok, 0);
    @(negedge clk); #1;
    cpu_cs = 0; pcm_cs = 0;
    rst_n = 1;
    m_vld_cpu = 0; m_vld_pcm = 0; m_next_pcm = 0;
    @(negedge clk); #1;
    req(0, 1, 0, 18'h20ABC);
    chk("t6_refetch_addr", log_back(1), map_pcm(18'h20ABC));
    pcm_cs = 0;

    // randomized traffic over small address pools so hits and misses mix
    for (int i = 0; i < 200; i++) begin
      lat   = $urandom_range(1, 5);
      stuck = ($urandom % 8) == 0;
      mode  = $urandom % 3;
      ca = 15'h0100 + 15'($urandom % 4);
      pa = (($urandom % 2) ? 18'h3FFF0 : 18'h00010) + 18'($urandom % 4);
      req(mode != 1, mode != 0, ca, pa);
      if ($urandom % 2) cpu_cs = 0;
      if ($urandom % 2) pcm_cs = 0;
      @(negedge clk); #1;
    end
    stuck = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
